vga_vram_scheduler: RTL and testbench
=====================================

// Module: vga_vram_scheduler
// PURPOSE
//  Time-slot scheduler for the single-port video RAM behind the 1280x1024 VGA timing generator.
//  Uses the timing generator's counter_x/counter_y to issue display fetches in fixed slots.
//  Grants all remaining RAM cycles to two write requesters (temperature readout, overlay/UI) by round-robin.
//  Framebuffer: 160x128 cells of 8x8 screen pixels, one byte per cell, address = cell_y*160 + cell_x.
// PARAMETERS
//  H_ACT_START  360   first active counter_x
//  H_ACT_END    1639  last active counter_x
//  V_ACT_START  41    first active counter_y
//  V_ACT_END    1064  last active counter_y
//  CELLS_X      160   cells per framebuffer row
//  CELLS_Y      128   framebuffer rows
//  ADDR_W       15    RAM address width
// PORTS
//  clk          in   1       pixel clock, shared with timing generator
//  rst          in   1       reset: synchronous, active-high
//  counter_x    in   11      horizontal count from timing generator
//  counter_y    in   11      vertical count from timing generator
//  vblank_only  in   1       1: writes granted only when counter_y outside [V_ACT_START,V_ACT_END]
//  w0_req       in   1       writer 0 request; held high until w0_ack
//  w0_addr      in   ADDR_W  writer 0 cell address
//  w0_data      in   8       writer 0 cell byte
//  w0_ack       out  1       one-cycle pulse: w0 write performed (or dropped if out of range)
//  w1_req/w1_addr/w1_data/w1_ack     same as writer 0, for writer 1
//  ram_en       out  1       RAM cycle enable
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  8       RAM write data
//  ram_rdata    in   8       RAM read data; valid exactly 1 cycle after a read cycle (ram_en=1, ram_we=0)
//  pix_byte     out  8       cell byte for the 8 current screen pixels
//  pix_valid    out  1       1 when counter_x/counter_y are inside the active window
//  frame_start  out  1       one-cycle pulse when counter_x==0 && counter_y==0
// BEHAVIOUR
//  Reset: all outputs 0.
//   Cell/row counters cleared; round-robin pointer = writer 0.
//   Pending requests remain un-acked and are served after reset releases.
//  Fetch slot: active line (V_ACT_START..V_ACT_END) && counter_x == H_ACT_START-2+8k, k=0..CELLS_X-1.
//   Read cycle: ram_en=1, ram_we=0, ram_addr = row_base + k.
//   ram_rdata captured 1 cycle later, then registered into pix_byte at counter_x = H_ACT_START+8k.
//   pix_byte holds for 8 pixels; 2-cycle fetch latency is fixed.
//  row_base: 0 at first active line.
//   += CELLS_X after every 8th active line (at counter_x==H_ACT_END+1 of that line).
//   Counter-based; no multiplier.
//  Outside active window pix_byte holds its last value, pix_valid=0.
//  Write cycle: any non-fetch cycle, subject to vblank_only, with >=1 req high.
//   Grant: if only one writer requests, that writer.
//   If both request, the writer selected by the pointer; pointer then moves to the other writer.
//   Granted writer: ram_en=1, ram_we=1, ram_addr/ram_wdata = its addr/data (registered).
//   Its ack pulses in that same cycle; the other ack stays 0.
//  Fetch slot beats any write; a blocked request waits with no ack.
//  Same requester may be granted on back-to-back cycles if the other is idle.
//  Address >= CELLS_X*CELLS_Y: ack pulses, ram_en=0 (write dropped, no RAM cycle).
//  req dropped before ack: no write, no ack, pointer unchanged.
//  ram_en=1 only on a fetch or a granted in-range write; never both in one cycle.
// TESTING
//  Reset mid-line with w0_req held:
//   -> all outputs 0 during rst; w0_ack first pulses on 1st eligible cycle after rst falls.
//  Line y=41, no writers:
//   -> reads at x=358,366,...,1630 with addr 0..159.
//   -> pix_byte = RAM[k] over x=360+8k..367+8k; pix_valid=1 for x 360..1639 only.
//  Line y=49 (9th active line) -> first fetch addr=160; line y=1064 -> first fetch addr=20320.
//  w0_req,w1_req held during vblank, w0_addr=5, w1_addr=7:
//   -> acks alternate w0,w1,w0...; RAM writes 5,7,5...
//  vblank_only=0, w1_req at y=100, x=366 (fetch slot):
//   -> no ack at x=366; write+ack at x=367.
//  vblank_only=1, w0_req at y=500 -> no ack until y=1065.
//  w0_addr=20480 -> w0_ack pulses, ram_en stays 0.

Source files
------------

// File: rtl/vga_vram_scheduler.sv
// Time-slot scheduler for the single-port video RAM behind the 1280x1024 timing
// generator. Display fetches own fixed slots 2 pixels ahead of each 8-pixel cell.
// Every other cycle is offered to two writers through a round-robin grant.
// All outputs are registered. An output seen after the clock edge at which
// counter_x == X is the decision for pixel X.
module vga_vram_scheduler #(
   parameter int unsigned H_ACT_START = 360,
   parameter int unsigned H_ACT_END   = 1639,
   parameter int unsigned V_ACT_START = 41,
   parameter int unsigned V_ACT_END   = 1064,
   parameter int unsigned CELLS_X     = 160,
   parameter int unsigned CELLS_Y     = 128,
   parameter int unsigned ADDR_W      = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       counter_x_i,
   input  logic [10:0]       counter_y_i,
   input  logic              vblank_only_i,
   input  logic              w0_req_i,
   input  logic [ADDR_W-1:0] w0_addr_i,
   input  logic [7:0]        w0_data_i,
   output logic              w0_ack_o,
   input  logic              w1_req_i,
   input  logic [ADDR_W-1:0] w1_addr_i,
   input  logic [7:0]        w1_data_i,
   output logic              w1_ack_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_wdata_o,
   input  logic [7:0]        ram_rdata_i,
   output logic [7:0]        pix_byte_o,
   output logic              pix_valid_o,
   output logic              frame_start_o
);

   localparam int unsigned COL_W = $clog2(CELLS_X + 1);

   localparam logic [10:0] X_FETCH_FIRST = 11'(H_ACT_START - 2);
   localparam logic [10:0] X_FETCH_LAST  = 11'(H_ACT_START - 2 + 8 * (CELLS_X - 1));
   localparam logic [10:0] X_ACT_START   = 11'(H_ACT_START);
   localparam logic [10:0] X_LOAD_LAST   = 11'(H_ACT_START + 8 * (CELLS_X - 1));
   localparam logic [10:0] X_ACT_END     = 11'(H_ACT_END);
   localparam logic [10:0] X_ROW_STEP    = 11'(H_ACT_END + 1);
   localparam logic [10:0] Y_ACT_START   = 11'(V_ACT_START);
   localparam logic [10:0] Y_ACT_END     = 11'(V_ACT_END);

   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(CELLS_X);
   localparam logic [ADDR_W-1:0] NUM_CELLS  = ADDR_W'(CELLS_X * CELLS_Y);

   logic [COL_W-1:0]  col_q;
   logic [ADDR_W-1:0] row_base_q;
   logic [2:0]        line_cnt_q;
   logic              ptr_q, ptr_d;

   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              w0_ack_q, w1_ack_q;
   logic              gnt0, gnt1;
   logic [7:0]        pix_byte_q;
   logic              pix_valid_q;
   logic              frame_start_q;

   logic              line_act;
   logic              fetch_span;
   logic              fetch_slot;
   logic              load_slot;
   logic              wr_eligible;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_data;
   logic              in_range;

   assign line_act   = (counter_y_i >= Y_ACT_START) && (counter_y_i <= Y_ACT_END);
   assign fetch_span = (counter_x_i >= X_FETCH_FIRST) && (counter_x_i <= X_FETCH_LAST);
   // Slot phase is compared on the low three bits only, because both grids have an 8-pixel pitch.
   assign fetch_slot = line_act && fetch_span
                       && (counter_x_i[2:0] == X_FETCH_FIRST[2:0]);
   assign load_slot  = line_act && (counter_x_i >= X_ACT_START) && (counter_x_i <= X_LOAD_LAST)
                       && (counter_x_i[2:0] == X_ACT_START[2:0]);
   assign fetch_addr = row_base_q + ADDR_W'(col_q);
   assign wr_eligible = !fetch_slot && (!vblank_only_i || !line_act);

   // Round-robin grant and RAM command selection; a fetch slot always wins.
   always_comb begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      ptr_d       = ptr_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (wr_eligible) begin
         if (w0_req_i && w1_req_i) begin
            gnt0  = !ptr_q;
            gnt1  = ptr_q;
            ptr_d = !ptr_q;
         end else begin
            gnt0 = w0_req_i;
            gnt1 = w1_req_i;
         end
      end
      sel_addr = gnt1 ? w1_addr_i : w0_addr_i;
      sel_data = gnt1 ? w1_data_i : w0_data_i;
      in_range = sel_addr < NUM_CELLS;
      if (fetch_slot) begin
         ram_en_d   = 1'b1;
         ram_addr_d = fetch_addr;
      end else if ((gnt0 || gnt1) && in_range) begin
         ram_en_d    = 1'b1;
         ram_we_d    = 1'b1;
         ram_addr_d  = sel_addr;
         ram_wdata_d = sel_data;
      end
   end

   // RAM command, acks and arbitration pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         w0_ack_q    <= 1'b0;
         w1_ack_q    <= 1'b0;
         ptr_q       <= 1'b0;
      end else begin
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         w0_ack_q    <= gnt0;
         w1_ack_q    <= gnt1;
         ptr_q       <= ptr_d;
      end
   end

   // Cell counter for the current line. It restarts whenever x leaves the fetch span.
   always_ff @(posedge clk) begin
      if (rst || !fetch_span) begin
         col_q <= '0;
      end else if (fetch_slot) begin
         col_q <= col_q + 1'b1;
      end
   end

   // Row base advances by one framebuffer row after each group of 8 active lines.
   always_ff @(posedge clk) begin
      if (rst || !line_act) begin
         row_base_q <= '0;
         line_cnt_q <= '0;
      end else if (counter_x_i == X_ROW_STEP) begin
         line_cnt_q <= line_cnt_q + 3'd1;
         if (line_cnt_q == 3'd7) begin
            row_base_q <= row_base_q + ROW_STRIDE;
         end
      end
   end

   // Pixel byte, active-window flag and frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_byte_q    <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         if (load_slot) begin
            pix_byte_q <= ram_rdata_i;
         end
         pix_valid_q   <= line_act && (counter_x_i >= X_ACT_START) && (counter_x_i <= X_ACT_END);
         frame_start_q <= (counter_x_i == 11'd0) && (counter_y_i == 11'd0);
      end
   end

   assign ram_en_o      = ram_en_q;
   assign ram_we_o      = ram_we_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_wdata_o   = ram_wdata_q;
   assign w0_ack_o      = w0_ack_q;
   assign w1_ack_o      = w1_ack_q;
   assign pix_byte_o    = pix_byte_q;
   assign pix_valid_o   = pix_valid_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Bench for vga_vram_scheduler. The bench drives counter_x/counter_y directly.
// A synchronous RAM model sits behind the DUT ports.
// Each cycle's expected outputs come from screen-geometry arithmetic
// plus a shadow copy of the framebuffer.
module tb_vga_vram_scheduler;

   localparam int NCELL = 20480;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] counter_x, counter_y;
   logic        vblank_only;
   logic        w0_req, w1_req;
   logic [14:0] w0_addr, w1_addr;
   logic [7:0]  w0_data, w1_data;
   logic        w0_ack, w1_ack;
   logic        ram_en, ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic [7:0]  pix_byte;
   logic        pix_valid, frame_start;

   logic [7:0]  mem     [0:NCELL-1];
   logic [7:0]  ref_mem [0:NCELL-1];

   int n_cmp = 0;
   int n_bad = 0;

   int   ptr_m = 0;
   logic [7:0] fetch_val = 8'h00;
   logic [7:0] pix_m = 8'h00;
   bit   e_en, e_we, e_a0, e_a1, e_pv, e_fs, e_rst;
   int   e_addr, e_data;
   bit   rnd_on = 0;

   always #5 clk = ~clk;

   vga_vram_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .counter_x_i   (counter_x),
      .counter_y_i   (counter_y),
      .vblank_only_i (vblank_only),
      .w0_req_i      (w0_req),
      .w0_addr_i     (w0_addr),
      .w0_data_i     (w0_data),
      .w0_ack_o      (w0_ack),
      .w1_req_i      (w1_req),
      .w1_addr_i     (w1_addr),
      .w1_data_i     (w1_data),
      .w1_ack_o      (w1_ack),
      .ram_en_o      (ram_en),
      .ram_we_o      (ram_we),
      .ram_addr_o    (ram_addr),
      .ram_wdata_o   (ram_wdata),
      .ram_rdata_i   (ram_rdata),
      .pix_byte_o    (pix_byte),
      .pix_valid_o   (pix_valid),
      .frame_start_o (frame_start)
   );

   // Synchronous single-port RAM: read data appears one cycle after the read command.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (x=%0d y=%0d)", tag, obs, exp, counter_x, counter_y);
      end
   endtask

   // One clock: derive the expected outputs from the current inputs, clock, then compare.
   task automatic cyc();
      int  x, y, k, faddr, g, a;
      bit  yact, fetch;
      x = int'(counter_x);
      y = int'(counter_y);
      yact  = (y >= 41) && (y <= 1064);
      fetch = yact && (x >= 358) && (x <= 1630) && ((x - 358) % 8 == 0);
      e_en = 0; e_we = 0; e_a0 = 0; e_a1 = 0; e_addr = 0; e_data = 0;
      e_rst = rst;
      if (rst) begin
         ptr_m = 0;
         pix_m = 8'h00;
         e_pv  = 0;
         e_fs  = 0;
      end else begin
         if (fetch) begin
            k     = (x - 358) / 8;
            faddr = ((y - 41) / 8) * 160 + k;
            e_en  = 1;
            e_addr = faddr;
            fetch_val = ref_mem[faddr];
         end else if ((!vblank_only || !yact) && (w0_req || w1_req)) begin
            if (w0_req && w1_req) begin
               g = ptr_m;
               ptr_m = 1 - ptr_m;
            end else begin
               g = w0_req ? 0 : 1;
            end
            if (g == 0) e_a0 = 1; else e_a1 = 1;
            a = (g == 0) ? int'(w0_addr) : int'(w1_addr);
            if (a < NCELL) begin
               e_en = 1; e_we = 1; e_addr = a;
               e_data = (g == 0) ? int'(w0_data) : int'(w1_data);
               ref_mem[a] = 8'(e_data);
            end
         end
         if (yact && (x >= 360) && (x <= 1632) && ((x - 360) % 8 == 0)) pix_m = fetch_val;
         e_pv = yact && (x >= 360) && (x <= 1639);
         e_fs = (x == 0) && (y == 0);
      end
      @(posedge clk);
      #1;
      chk("w0_ack", w0_ack, e_a0);
      chk("w1_ack", w1_ack, e_a1);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      if (e_en || e_rst) chk("ram_addr", ram_addr, e_addr);
      if (e_we || e_rst) chk("ram_wdata", ram_wdata, e_data);
      chk("pix_byte", pix_byte, pix_m);
      chk("pix_valid", pix_valid, e_pv);
      chk("frame_start", frame_start, e_fs);
   endtask

   task automatic new_req(output logic [14:0] a, output logic [7:0] d);
      if ($urandom_range(0, 9) == 0) a = 15'($urandom_range(NCELL, 32767));
      else                           a = 15'($urandom_range(0, NCELL - 1));
      d = 8'($urandom);
   endtask

   // Random requesters: hold until acked, sometimes withdraw, sometimes reissue at once.
   task automatic upd_req();
      if (!rnd_on) return;
      if (e_a0) begin
         w0_req = ($urandom_range(0, 9) < 6);
         new_req(w0_addr, w0_data);
      end else if (w0_req && $urandom_range(0, 19) == 0) begin
         w0_req = 0;
      end else if (!w0_req && $urandom_range(0, 9) < 3) begin
         w0_req = 1;
         new_req(w0_addr, w0_data);
      end
      if (e_a1) begin
         w1_req = ($urandom_range(0, 9) < 6);
         new_req(w1_addr, w1_data);
      end else if (w1_req && $urandom_range(0, 19) == 0) begin
         w1_req = 0;
      end else if (!w1_req && $urandom_range(0, 9) < 3) begin
         w1_req = 1;
         new_req(w1_addr, w1_data);
      end
   endtask

   initial begin
      int xs[$];
      int held_acks;
      for (int i = 0; i < NCELL; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      rst = 1; vblank_only = 0;
      counter_y = 11'd1065; counter_x = 11'd790;
      w0_req = 1; w0_addr = 15'd3; w0_data = 8'h11;
      w1_req = 0; w1_addr = 15'd0; w1_data = 8'h00;

      // Power-up reset, then a second reset mid-line while w0 is held.
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_w0_ack", w0_ack, 0);
         counter_x = counter_x + 11'd1;
      end
      rst = 0;
      cyc();
      chk("first_ack_after_rst", w0_ack, 1);
      counter_x = counter_x + 11'd1;
      w0_req = 0;
      cyc(); counter_x = counter_x + 11'd1;
      w0_req = 1; w0_data = 8'h22; rst = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_mid_ram_en", ram_en, 0);
         counter_x = counter_x + 11'd1;
      end
      rst = 0;
      cyc();
      chk("ack_after_mid_rst", w0_ack, 1);
      w0_req = 0;

      // Frame start pulse.
      counter_y = 11'd0; counter_x = 11'd0;
      cyc();
      chk("frame_start_pulse", frame_start, 1);
      counter_x = 11'd1;
      cyc();

      // Both writers held in vblank: strict alternation.
      counter_y = 11'd10; counter_x = 11'd100;
      w0_req = 1; w0_addr = 15'd5; w0_data = 8'hA5;
      w1_req = 1; w1_addr = 15'd7; w1_data = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("alt_w0_ack", w0_ack, (i % 2 == 0) ? 1 : 0);
         chk("alt_addr", ram_addr, (i % 2 == 0) ? 5 : 7);
         counter_x = counter_x + 11'd1;
      end
      w1_req = 0;

      // Out-of-range address: acked, no RAM cycle.
      w0_addr = 15'd20480;
      cyc();
      chk("oor_ack", w0_ack, 1);
      chk("oor_ram_en", ram_en, 0);
      w0_req = 0;
      counter_x = counter_x + 11'd1;
      cyc();

      // First active line, full sweep with random writers.
      rnd_on = 1;
      counter_y = 11'd41;
      for (int x = 340; x <= 1645; x++) begin
         counter_x = 11'(x);
         cyc();
         if (x == 358)  chk("y41_first_fetch", ram_addr, 0);
         if (x == 1630) chk("y41_last_fetch", ram_addr, 159);
         upd_req();
      end

      // Remaining active lines: first two cells plus the row-step point.
      for (int x = 356; x <= 368; x++) xs.push_back(x);
      for (int x = 1638; x <= 1641; x++) xs.push_back(x);
      held_acks = 0;
      for (int y = 42; y <= 1064; y++) begin
         counter_y = 11'(y);
         if (y == 100) begin
            rnd_on = 0; w0_req = 0; w1_req = 0;
         end
         if (y == 101) rnd_on = 1;
         if (y == 500) begin
            rnd_on = 0; vblank_only = 1;
            w0_req = 1; w0_addr = 15'd1234; w0_data = 8'h3C;
            w1_req = 0;
         end
         foreach (xs[i]) begin
            counter_x = 11'(xs[i]);
            if (y == 100 && xs[i] == 366) begin
               w1_req = 1; w1_addr = 15'd4321; w1_data = 8'h77;
            end
            cyc();
            if (y == 49   && xs[i] == 358) chk("y49_first_fetch", ram_addr, 160);
            if (y == 1064 && xs[i] == 358) chk("y1064_first_fetch", ram_addr, 20320);
            if (y == 100 && xs[i] == 366) chk("slot_blocks_w1", w1_ack, 0);
            if (y == 100 && xs[i] == 367) begin
               chk("w1_after_slot_ack", w1_ack, 1);
               chk("w1_after_slot_we", ram_we, 1);
               w1_req = 0;
            end
            if (y >= 500 && w0_ack) held_acks++;
            upd_req();
         end
      end
      chk("vblank_only_no_ack", held_acks, 0);

      // Leaving the active window releases the held vblank-only write.
      counter_y = 11'd1065; counter_x = 11'd0;
      cyc();
      chk("vblank_release_ack", w0_ack, 1);
      chk("vblank_release_addr", ram_addr, 1234);
      w0_req = 0;
      counter_x = 11'd1;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
